ysyx_22050612_mem_arbiter: RTL and testbench
============================================

Name:
ysyx_22050612_mem_arbiter

Overview:
- Shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store path of the execute unit (LSU).
- One outstanding transaction at a time; LSU has priority, bounded by an aging counter so fetch cannot starve.
- Sits between IFU/EXU and the memory wrapper; replaces direct combinational pmem access with a valid/ready request and a response-valid return.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; wmask width is DATA_W/8
MAX_WAIT, 4, cycles IFU may be refused while LSU wins before IFU gets priority; 0 = strict LSU priority

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
ifu_req_valid  input  1  fetch request
ifu_req_ready  output  1  fetch request accepted this cycle
ifu_addr  input  ADDR_W  fetch address
ifu_resp_valid  output  1  one-cycle pulse, fetch data on resp_rdata
lsu_req_valid  input  1  load/store request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_addr  input  ADDR_W  load/store address
lsu_wen  input  1  1 = store, 0 = load
lsu_wdata  input  DATA_W  store data
lsu_wmask  input  DATA_W/8  store byte mask
lsu_resp_valid  output  1  one-cycle pulse; load data on resp_rdata, or store completion
resp_rdata  output  DATA_W  read data, valid only with a resp_valid pulse
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  registered address
mem_wen  output  1  registered write enable
mem_wdata  output  DATA_W  registered write data
mem_wmask  output  DATA_W/8  registered mask
mem_resp_valid  input  1  memory response, one cycle
mem_rdata  input  DATA_W  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT. Reset → IDLE. Reset clears all registered outputs, owner, and age counter to 0.
- Under reset, all outputs are 0. Reset mid-transaction drops the transaction with no response; the memory wrapper shares rst.
- IDLE, arbitration: the winner is LSU if lsu_req_valid, unless ifu_req_valid and age ≥ MAX_WAIT (MAX_WAIT > 0), in which case the winner is IFU. Otherwise the winner is IFU if only IFU is valid.
- Only the winner's *_req_ready = 1, combinationally, and only in IDLE. Both readies are 0 in ISSUE and WAIT.
- On acceptance: latch addr, wen, wdata, wmask and owner. For IFU: wen = 0, wmask = 0. Next state is ISSUE.
- ISSUE: mem_req_valid = 1 and the mem_* outputs stay stable until mem_req_ready. Handshake → WAIT.
- WAIT: on mem_resp_valid, pulse the owner's resp_valid in the same cycle and pass mem_rdata to resp_rdata; next state is IDLE.
- Minimum round trip: accept at T, issue at T+1, response at T+2, next accept at T+3.
- mem_resp_valid outside WAIT is ignored. resp_rdata = 0 when no resp_valid is asserted.
- Age counter: increments each cycle ifu_req_valid = 1 and ifu_req_ready = 0, saturating at MAX_WAIT. It clears on IFU acceptance or when ifu_req_valid = 0.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.
- Address and data are passed unchanged; alignment and byte selection belong to the requester.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/WAIT), owner encoding (OWN_IFU = 0, OWN_LSU = 1), default widths.
- One natural sub-module: ysyx_22050612_arb_age, the saturating aging counter with grant/clear inputs.

Test Plan:
- Single IFU read at addr 0x80000000; memory ready immediately and responds next cycle with 0x00100073 → ifu_resp_valid at T+2, resp_rdata = 0x00100073, lsu_resp_valid = 0.
- Both valid in the same cycle with age 0 → LSU accepted first, IFU accepted at the next IDLE; responses occur in order LSU then IFU.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xFF; mem_req_ready held low for 3 cycles → mem_* stable for all 4 ISSUE cycles, lsu_resp_valid pulses once with resp_rdata = 0.
- LSU valid continuously and IFU valid, MAX_WAIT = 4 → IFU granted once its age reaches 4, no later than the 5th arbitration; age returns to 0.
- rst asserted during WAIT → all outputs 0 immediately; a later mem_resp_valid is ignored; after release, a new IFU read completes normally.

Source files
------------

// File: rtl/ysyx_22050612_mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
// No logic; latency and backpressure live in the modules that import this.
package ysyx_22050612_mem_arbiter_pkg;

    localparam int DEF_ADDR_W   = 64;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_MAX_WAIT = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Age counter must hold MAX_WAIT itself; keep at least one bit when MAX_WAIT = 0.
    function automatic int age_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22050612_mem_arbiter_if.sv
// Request/response bundle between IFU+LSU, the arbiter and the memory wrapper.
// slave = arbiter view; master = requesters plus memory wrapper view.
interface ysyx_22050612_mem_arbiter_if
    import ysyx_22050612_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_resp_valid;
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid,
        output lsu_req_ready, lsu_resp_valid, resp_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid,
        input  lsu_req_ready, lsu_resp_valid, resp_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx_22050612_arb_age.sv
// Saturating count of cycles the IFU has been refused; sat flags it is due priority.
// One-cycle update latency; clears on IFU grant or when the IFU drops its request.
module ysyx_22050612_arb_age
    import ysyx_22050612_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic grant,
    output logic sat
);
    localparam int               AGE_W   = age_width(MAX_WAIT);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (!req || grant) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end

    // With MAX_WAIT = 0 the counter never leaves 0 and LSU priority is strict.
    assign sat = (MAX_WAIT > 0) && (age == AGE_MAX);

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Single-outstanding arbiter of IFU/LSU onto one memory port, LSU first with IFU aging.
// Accept -> issue next cycle, response passed through same cycle; readies drop while busy.
module ysyx_22050612_mem_arbiter
    import ysyx_22050612_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22050612_mem_arbiter_if.slave  bus
);
    logic [1:0]          state;
    owner_e              owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;

    logic ifu_aged;
    logic lsu_win;
    logic ifu_win;
    logic idle_open;
    logic lsu_acc;
    logic ifu_acc;
    logic resp_fire;

    ysyx_22050612_arb_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.ifu_req_valid),
        .grant (ifu_acc),
        .sat   (ifu_aged)
    );

    assign lsu_win   = bus.lsu_req_valid && !(bus.ifu_req_valid && ifu_aged);
    assign ifu_win   = bus.ifu_req_valid && !lsu_win;
    // Readies are combinational, so gate with rst to keep every output low in reset.
    assign idle_open = (state == S_IDLE) && !rst;
    assign lsu_acc   = idle_open && lsu_win;
    assign ifu_acc   = idle_open && ifu_win;
    assign resp_fire = (state == S_WAIT) && bus.mem_resp_valid;

    assign bus.lsu_req_ready  = lsu_acc;
    assign bus.ifu_req_ready  = ifu_acc;
    assign bus.lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    assign bus.ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    assign bus.resp_rdata     = resp_fire ? bus.mem_rdata : '0;
    assign bus.mem_req_valid  = (state == S_ISSUE);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_acc) begin
                        addr_q  <= bus.lsu_addr;
                        wen_q   <= bus.lsu_wen;
                        wdata_q <= bus.lsu_wdata;
                        wmask_q <= bus.lsu_wmask;
                        owner   <= OWN_LSU;
                        state   <= S_ISSUE;
                    end else if (ifu_acc) begin
                        addr_q  <= bus.ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        owner   <= OWN_IFU;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed and random checks of the memory arbiter against a transaction-level model.
module tb_ysyx_22050612_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_22050612_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          own_lsu;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        bit          issued;
    } txn_t;

    int   vectors = 0;
    int   miscompares = 0;
    txn_t cur_q[$];
    int   age = 0;
    bit   rnd_mode = 0;
    bit   knob_spur = 0;
    int   knob_stall = 0;
    int   knob_resp = 0;
    int   stall_left = 0;
    int   resp_left = 0;
    bit   acc_ifu, acc_lsu;
    logic obs_ifu_rdy, obs_lsu_rdy, obs_ifu_resp, obs_lsu_resp, obs_mreq;
    logic [63:0] obs_rdata;
    bit   obs_order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_val(input txn_t t);
        if (t.wen) return 64'h0;
        if (t.addr == 64'h8000_0000) return 64'h0000_0000_0010_0073;
        return {~t.addr[31:0], t.addr[31:0] ^ 32'h5a5a_a5a5};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".ifu_req_ready"},  64'(bus.ifu_req_ready),  64'h0);
        check({tag, ".lsu_req_ready"},  64'(bus.lsu_req_ready),  64'h0);
        check({tag, ".ifu_resp_valid"}, 64'(bus.ifu_resp_valid), 64'h0);
        check({tag, ".lsu_resp_valid"}, 64'(bus.lsu_resp_valid), 64'h0);
        check({tag, ".resp_rdata"},     bus.resp_rdata,          64'h0);
        check({tag, ".mem_req_valid"},  64'(bus.mem_req_valid),  64'h0);
        check({tag, ".mem_addr"},       bus.mem_addr,            64'h0);
        check({tag, ".mem_wen"},        64'(bus.mem_wen),        64'h0);
        check({tag, ".mem_wdata"},      bus.mem_wdata,           64'h0);
        check({tag, ".mem_wmask"},      64'(bus.mem_wmask),      64'h0);
    endtask

    task automatic drive_mem();
        bit has;
        has = (cur_q.size() != 0);
        if (has && !cur_q[0].issued) bus.mem_req_ready = (stall_left == 0);
        else bus.mem_req_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        if (has && cur_q[0].issued) begin
            bus.mem_resp_valid = (resp_left == 0);
            bus.mem_rdata = (resp_left == 0) ? mem_val(cur_q[0]) : {$urandom, $urandom};
        end else begin
            bus.mem_resp_valid = knob_spur || (rnd_mode && $urandom_range(0, 3) == 0);
            bus.mem_rdata = {$urandom, $urandom};
        end
    endtask

    // One clock: drive memory, compare against the model, advance the model.
    task automatic step();
        bit   idle, pri, e_lsu_rdy, e_ifu_rdy, e_mreq, e_resp;
        txn_t t, n;
        drive_mem();
        #1;
        idle = (cur_q.size() == 0);
        if (!idle) t = cur_q[0];
        pri       = bus.ifu_req_valid && (MW > 0) && (age >= MW);
        e_lsu_rdy = idle && bus.lsu_req_valid && !pri;
        e_ifu_rdy = idle && bus.ifu_req_valid && !e_lsu_rdy;
        e_mreq    = !idle && !t.issued;
        e_resp    = !idle && t.issued && bus.mem_resp_valid;

        obs_ifu_rdy  = bus.ifu_req_ready;
        obs_lsu_rdy  = bus.lsu_req_ready;
        obs_ifu_resp = bus.ifu_resp_valid;
        obs_lsu_resp = bus.lsu_resp_valid;
        obs_mreq     = bus.mem_req_valid;
        obs_rdata    = bus.resp_rdata;

        check("ifu_req_ready",  64'(obs_ifu_rdy),  64'(e_ifu_rdy));
        check("lsu_req_ready",  64'(obs_lsu_rdy),  64'(e_lsu_rdy));
        check("mem_req_valid",  64'(obs_mreq),     64'(e_mreq));
        if (e_mreq) begin
            check("mem_addr",  bus.mem_addr,       t.addr);
            check("mem_wen",   64'(bus.mem_wen),   64'(t.wen));
            check("mem_wmask", 64'(bus.mem_wmask), 64'(t.wmask));
            if (t.wen) check("mem_wdata", bus.mem_wdata, t.wdata);
        end
        check("ifu_resp_valid", 64'(obs_ifu_resp), 64'(e_resp && !t.own_lsu));
        check("lsu_resp_valid", 64'(obs_lsu_resp), 64'(e_resp && t.own_lsu));
        check("resp_rdata",     obs_rdata,         e_resp ? mem_val(t) : 64'h0);
        if (obs_lsu_resp === 1'b1) obs_order.push_back(1'b1);
        if (obs_ifu_resp === 1'b1) obs_order.push_back(1'b0);

        if (bus.ifu_req_valid && !e_ifu_rdy) age = (age < MW) ? age + 1 : MW;
        else age = 0;
        if (e_resp) begin
            void'(cur_q.pop_front());
        end else if (e_mreq) begin
            if (bus.mem_req_ready) begin
                t.issued = 1'b1;
                cur_q[0] = t;
            end else begin
                stall_left--;
            end
        end else if (!idle) begin
            resp_left--;
        end
        if (e_lsu_rdy || e_ifu_rdy) begin
            n.own_lsu = e_lsu_rdy;
            n.addr    = e_lsu_rdy ? bus.lsu_addr : bus.ifu_addr;
            n.wen     = e_lsu_rdy && bus.lsu_wen;
            n.wdata   = e_lsu_rdy ? bus.lsu_wdata : 64'h0;
            n.wmask   = e_lsu_rdy ? bus.lsu_wmask : 8'h0;
            n.issued  = 1'b0;
            cur_q.push_back(n);
            stall_left = rnd_mode ? int'($urandom_range(0, 3)) : knob_stall;
            resp_left  = rnd_mode ? int'($urandom_range(0, 3)) : knob_resp;
        end
        acc_ifu = e_ifu_rdy;
        acc_lsu = e_lsu_rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (cur_q.size() == 0) break;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n_mreq, n_resp, arbs, ifu_at;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 64'h0;
        bus.lsu_wmask     = 8'h0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hffff_ffff_ffff_ffff;
        #1;
        check_zero("reset");
        @(negedge clk);
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single IFU fetch, minimum round trip.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        step();
        check("fetch.accept_T", 64'(obs_ifu_rdy), 64'h1);
        bus.ifu_req_valid = 1'b0;
        step();
        check("fetch.issue_T1", 64'(obs_mreq), 64'h1);
        step();
        check("fetch.resp_T2", 64'(obs_ifu_resp), 64'h1);
        check("fetch.rdata_T2", obs_rdata, 64'h0000_0000_0010_0073);
        check("fetch.no_lsu_resp", 64'(obs_lsu_resp), 64'h0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0004;
        step();
        check("fetch.accept_T3", 64'(obs_ifu_rdy), 64'h1);
        bus.ifu_req_valid = 1'b0;
        drain();

        // Both request together with age 0: LSU then IFU.
        obs_order.delete();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0008;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_2000;
        bus.lsu_wen       = 1'b0;
        step();
        check("both.lsu_first", 64'(obs_lsu_rdy), 64'h1);
        check("both.ifu_held", 64'(obs_ifu_rdy), 64'h0);
        bus.lsu_req_valid = 1'b0;
        for (int i = 0; i < 10 && bus.ifu_req_valid; i++) begin
            step();
            if (acc_ifu) bus.ifu_req_valid = 1'b0;
        end
        drain();
        check("both.resp_count", 64'(obs_order.size()), 64'd2);
        if (obs_order.size() == 2) begin
            check("both.first_is_lsu", 64'(obs_order[0]), 64'h1);
            check("both.second_is_ifu", 64'(obs_order[1]), 64'h0);
        end

        // Store with memory stalling for three cycles.
        knob_stall = 3;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 64'h0000_0000_dead_beef;
        bus.lsu_wmask     = 8'hff;
        step();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wen       = 1'b0;
        n_mreq = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_mreq === 1'b1) n_mreq++;
        end
        check("store.issue_cycles", 64'(n_mreq), 64'd4);
        n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_lsu_resp === 1'b1) begin
                n_resp++;
                check("store.rdata", obs_rdata, 64'h0);
            end
        end
        check("store.resp_pulses", 64'(n_resp), 64'd1);
        knob_stall = 0;

        // LSU saturating the port: IFU must age into priority.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0010;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_3000;
        arbs = 0;
        ifu_at = 99;
        for (int i = 0; i < 60 && ifu_at == 99; i++) begin
            step();
            if (obs_lsu_rdy === 1'b1) arbs++;
            if (obs_ifu_rdy === 1'b1) begin
                arbs++;
                ifu_at = arbs;
            end
            if (acc_lsu) bus.lsu_addr = bus.lsu_addr + 64'd8;
        end
        check("age.ifu_granted_by_5th", 64'(ifu_at >= 2 && ifu_at <= 5), 64'h1);
        bus.ifu_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_lsu) begin
                bus.lsu_req_valid = 1'b0;
                break;
            end
        end
        bus.lsu_req_valid = 1'b0;
        drain();

        // Reset while waiting for a response.
        knob_resp = 3;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0020;
        step();
        bus.ifu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h1234_5678_9abc_def0;
        #1;
        check_zero("rst_in_wait");
        cur_q.delete();
        age = 0;
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b0;
        knob_resp = 0;
        knob_spur = 1;
        step();
        check("rst.spurious_ignored", 64'(obs_ifu_resp | obs_lsu_resp), 64'h0);
        knob_spur = 0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        step();
        check("rst.refetch_accept", 64'(obs_ifu_rdy), 64'h1);
        bus.ifu_req_valid = 1'b0;
        step();
        step();
        check("rst.refetch_resp", 64'(obs_ifu_resp), 64'h1);
        check("rst.refetch_rdata", obs_rdata, 64'h0000_0000_0010_0073);

        // Random traffic with random memory timing and stray responses.
        rnd_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!bus.ifu_req_valid && $urandom_range(0, 3) == 0) begin
                bus.ifu_req_valid = 1'b1;
                bus.ifu_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
            end
            if (!bus.lsu_req_valid && $urandom_range(0, 2) == 0) begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_addr  = {32'h0, 32'h8001_0000 | ($urandom & 32'h0000_fff8)};
                bus.lsu_wen   = 1'($urandom_range(0, 1));
                bus.lsu_wdata = {$urandom, $urandom};
                bus.lsu_wmask = 8'($urandom);
            end
            step();
            if (acc_ifu) bus.ifu_req_valid = 1'b0;
            if (acc_lsu) bus.lsu_req_valid = 1'b0;
        end
        for (int i = 0; i < 40 && (bus.ifu_req_valid || bus.lsu_req_valid); i++) begin
            step();
            if (acc_ifu) bus.ifu_req_valid = 1'b0;
            if (acc_lsu) bus.lsu_req_valid = 1'b0;
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rnd_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
